// File: rtl/mbus_rd_ctl.sv
// mbus_rd_ctl -- memory-bus read controller.
//
// Accepts a quadword read request from the CPU side, issues it to memory on
// phase A or phase B, collects the returned words and queues them in an
// 8-entry FIFO for the consumer. A request that is never acknowledged is
// aborted after NXM_TIMEOUT cycles with a one-cycle nxm pulse.
//
// Build option:
//   MBUS_PARITY_CHECK_EN  when defined, each captured word is tagged with a
//                         parity error flag (mbPar != ^mbData); when not
//                         defined the flag is always 0 and mbPar is unused.
//
// Ports:
//   clk, reset        single clock; asynchronous active-high reset
//   reqValid/Ready    CPU request handshake
//   reqAdr[21:0]      word address bits 14:35 (reqAdr[1:0] = bits 34:35)
//   reqRq[3:0]        word-request mask, reqRq[0] = first word of quadword
//   reqPhB            0 = phase A, 1 = phase B
//   mbAdr, mbRq       latched address / request mask presented to memory
//   mbAdrHold         address stable while a transfer is in progress
//   mbStartA/B        start strobe for the selected phase
//   mbAcknA/B         word acknowledge per phase
//   mbValidA/B        read data valid per phase
//   mbData, mbPar     read data and its parity bit
//   wdValid/Ready     consumer handshake on the word FIFO head
//   wdData/Wo/ParErr  head word, its offset within the quadword, parity flag
//   nxm               one-cycle pulse when a request times out
//
// State table:
//   state | meaning
//   IDLE  | no transfer; request may be accepted when FIFO has room for 4
//   START | start strobe asserted, waiting for ACKN of the selected phase
//   XFER  | acknowledged; capturing the remaining requested words
module mbus_rd_ctl #(
    parameter int NXM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [21:0] reqAdr,
    input  logic [3:0]  reqRq,
    input  logic        reqPhB,
    output logic [21:0] mbAdr,
    output logic        mbAdrHold,
    output logic [3:0]  mbRq,
    output logic        mbStartA,
    output logic        mbStartB,
    input  logic        mbAcknA,
    input  logic        mbAcknB,
    input  logic        mbValidA,
    input  logic        mbValidB,
    input  logic [35:0] mbData,
    input  logic        mbPar,
    output logic        wdValid,
    input  logic        wdReady,
    output logic [35:0] wdData,
    output logic [1:0]  wdWo,
    output logic        wdParErr,
    output logic        nxm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    // Timer counts 0 .. NXM_TIMEOUT-1 while in START; abort on the last value.
    localparam int TW = (NXM_TIMEOUT < 2) ? 1 : $clog2(NXM_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(NXM_TIMEOUT - 1);

    localparam int FIFO_W = 36 + 2 + 1;

    state_t          state;
    state_t          state_nxt;

    logic [21:0]     adr_q;
    logic [3:0]      rq_q;
    logic            phb_q;
    logic            start_a_q;
    logic            start_b_q;
    logic            nxm_q;

    // Working mask: bit 0 is the word slot currently on the bus.
    logic [3:0]      mask_q;
    logic [3:0]      mask_nxt;
    logic [1:0]      wo_q;
    logic [1:0]      wo_nxt;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_nxt;

    logic            accept;
    logic            ackn_sel;
    logic            valid_sel;
    logic            push;
    logic            pop;
    logic            abort;
    logic            par_err;
    logic            unused_bits;

    logic [FIFO_W-1:0] fifo_mem [8];
    logic [2:0]        wr_ptr;
    logic [2:0]        rd_ptr;
    logic [3:0]        count_q;
    logic [FIFO_W-1:0] head;

    // ------------------------------------------------------------------
    // Parity tagging
    // ------------------------------------------------------------------
`ifdef MBUS_PARITY_CHECK_EN
    assign par_err     = mbPar ^ (^mbData);
    assign unused_bits = reqRq[0];
`else
    assign par_err     = 1'b0;
    assign unused_bits = reqRq[0] ^ mbPar;
`endif

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    // Accepting only with <=4 words queued guarantees a full quadword always
    // fits, so memory never needs to be stalled.
    assign reqReady = (state == IDLE) && (count_q <= 4'd4);
    assign accept   = reqValid && reqReady;

    // Only the selected phase is listened to; the other phase belongs to a
    // different requester.
    assign ackn_sel  = phb_q ? mbAcknB  : mbAcknA;
    assign valid_sel = phb_q ? mbValidB : mbValidA;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        wo_nxt    = wo_q;
        timer_nxt = timer_q;
        push      = 1'b0;
        abort     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    // Word 0 is always fetched regardless of reqRq[0].
                    mask_nxt  = {reqRq[3:1], 1'b1};
                    wo_nxt    = reqAdr[1:0];
                    timer_nxt = '0;
                end
            end

            START: begin
                if (ackn_sel) begin
                    push     = valid_sel;
                    mask_nxt = {1'b0, mask_q[3:1]};
                    wo_nxt   = wo_q + 2'd1;
                    if (mask_q[3:1] != 3'd0) begin
                        state_nxt = XFER;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer_q + TW'(1);
                end
            end

            XFER: begin
                // One word slot per cycle; unrequested slots are skipped.
                push     = mask_q[0] && valid_sel;
                mask_nxt = {1'b0, mask_q[3:1]};
                wo_nxt   = wo_q + 2'd1;
                if (mask_q[3:1] == 3'd0) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and working counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mask_q  <= '0;
            wo_q    <= '0;
            timer_q <= '0;
        end else begin
            state   <= state_nxt;
            mask_q  <= mask_nxt;
            wo_q    <= wo_nxt;
            timer_q <= timer_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latches, start strobes, nxm pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q     <= '0;
            rq_q      <= '0;
            phb_q     <= 1'b0;
            start_a_q <= 1'b0;
            start_b_q <= 1'b0;
            nxm_q     <= 1'b0;
        end else begin
            nxm_q <= abort;
            if (accept) begin
                adr_q     <= reqAdr;
                rq_q      <= {reqRq[3:1], 1'b1};
                phb_q     <= reqPhB;
                start_a_q <= !reqPhB;
                start_b_q <= reqPhB;
            end else if ((state == START) && (state_nxt != START)) begin
                // Leaving START by ACKN or by timeout drops the strobe.
                start_a_q <= 1'b0;
                start_b_q <= 1'b0;
            end
        end
    end

    assign mbAdr     = adr_q;
    assign mbRq      = rq_q;
    assign mbAdrHold = (state != IDLE);
    assign mbStartA  = start_a_q;
    assign mbStartB  = start_b_q;
    assign nxm       = nxm_q;

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    assign pop = wdValid && wdReady;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {mbData, wo_q, par_err};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; gating the head with wdValid keeps the outputs
    // at zero whenever the FIFO is empty, including straight after reset.
    assign head     = fifo_mem[rd_ptr];
    assign wdValid  = (count_q != 4'd0);
    assign wdData   = wdValid ? head[FIFO_W-1:3] : 36'd0;
    assign wdWo     = wdValid ? head[2:1]        : 2'd0;
    assign wdParErr = wdValid ? head[0]          : 1'b0;

endmodule

// File: doc/mbus_rd_ctl.md
MBUS_RD_CTL -- requirements
Module: mbus_rd_ctl
Interface
REQ-001 SHALL have parameter: NXM_TIMEOUT, 255, cycles in START without ACKN before nonexistent-memory abort.
REQ-002 SHALL have port: clk  in  1  single clock for all logic (memory phase A/B signals synchronous to it).
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: reqValid  in  1  CPU-side read request present.
REQ-005 SHALL have port: reqReady  out  1  request accepted when reqValid&&reqReady at posedge clk.
REQ-006 SHALL have port: reqAdr  in  22  word address bits 14:35.
REQ-007 SHALL have port: reqRq  in  4  quadword word-request mask, bit 0 first word.
REQ-008 SHALL have port: reqPhB  in  1  0 = use phase A, 1 = use phase B.
REQ-009 SHALL have port: mbAdr  out  22  latched address to memory.
REQ-010 SHALL have port: mbAdrHold  out  1  address stable; memory latches mbAdr.
REQ-011 SHALL have port: mbRq  out  4  latched request mask to memory.
REQ-012 SHALL have port: mbStartA  out  1  start on phase A.
REQ-013 SHALL have port: mbStartB  out  1  start on phase B.
REQ-014 SHALL have port: mbAcknA  in  1  phase A word acknowledge.
REQ-015 SHALL have port: mbAcknB  in  1  phase B word acknowledge.
REQ-016 SHALL have port: mbValidA  in  1  phase A read data valid.
REQ-017 SHALL have port: mbValidB  in  1  phase B read data valid.
REQ-018 SHALL have port: mbData  in  36  read data from memory.
REQ-019 SHALL have port: mbPar  in  1  read data parity (equals XOR of mbData when good).
REQ-020 SHALL have port: wdValid  out  1  buffered word available.
REQ-021 SHALL have port: wdReady  in  1  consumer pops word when wdValid&&wdReady.
REQ-022 SHALL have port: wdData  out  36  head-of-buffer data word.
REQ-023 SHALL have port: wdWo  out  2  word offset within quadword of wdData.
REQ-024 SHALL have port: wdParErr  out  1  parity error flag for wdData.
REQ-025 SHALL have port: nxm  out  1  one-cycle pulse on timeout abort.
Function
REQ-026 SHALL implement states IDLE, START, XFER; reqReady = (state==IDLE) && bufCount<=4.
REQ-027 SHALL on accept latch adr, phase and mask {1,reqRq[1:3]} (word 0 always requested), clear timer, go START.
REQ-028 SHALL drive mbAdr/mbRq from latches and mbAdrHold=1 in START and XFER; 0 in IDLE.
REQ-029 SHALL assert only the selected mbStart, registered, in START only; it deasserts the cycle after ACKN.
REQ-030 SHALL in START ignore unselected-phase ACKN/VALID; selected ACKN with VALID pushes word, wo=adr[34:35].
REQ-031 SHALL after first ACKN set mask=rq<<1, wo=adr[34:35]+1 mod 4; go XFER if mask!=0 else IDLE.
REQ-032 SHALL in XFER each cycle push {mbData, wo, parErr} if mask[0] and selected VALID; then mask<<=1, wo+=1 mod 4; IDLE when mask becomes 0.
REQ-033 SHALL abort when timer reaches NXM_TIMEOUT in START: pulse nxm, drop start, IDLE, push nothing.
REQ-034 SHALL buffer words in 8-entry FIFO, never back-pressure memory; wdValid = count!=0; simultaneous push/pop leaves count unchanged.
REQ-035 SHALL deliver words in capture order; wdData/wdWo/wdParErr held stable while wdValid&&!wdReady.
Reset
REQ-036 SHALL on reset assertion immediately force IDLE, all mb* outputs 0, nxm=0, FIFO empty (wdValid=0, wdData=0, wdWo=0, wdParErr=0), timer/mask/wo 0; mid-transfer words discarded.
Configuration
REQ-037 SHALL, with MBUS_PARITY_CHECK_EN defined, capture parErr = mbPar != ^mbData; without it, parErr is 0 and mbPar ignored.
Verification
REQ-038 SHALL cover: adr=0o1000, rq=1111, phase A, ACKN+VALID 2 cycles after start -> 4 words, wdWo 0,1,2,3, mbStartA high exactly until ACKN cycle+1.
REQ-039 SHALL cover: adr=0o1002, rq=1010, phase B -> 2 words, wdWo 2 then 0, mbStartA never asserted.
REQ-040 SHALL cover: no ACKN for 255 cycles -> nxm pulse one cycle, state IDLE, wdValid stays 0.
REQ-041 SHALL cover: wdReady=0 across two rq=1111 requests -> second reqReady withheld until count<=4, no word lost, order preserved.
REQ-042 SHALL cover: mbPar inverted on word 1 with MBUS_PARITY_CHECK_EN -> wdParErr=1 only on word 1; without macro -> 0.
REQ-043 SHALL cover: reset asserted during XFER -> outputs zero without clock edge; next request completes normally.
